// File: rtl/taxi_eth_phy_10g_link_ctrl_pkg.sv
// Shared types for the 10G BASE-R link bring-up controller.
package taxi_eth_phy_10g_link_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED    = 3'd0,
        ST_RESET       = 3'd1,
        ST_WAIT_LOCK   = 3'd2,
        ST_WAIT_STABLE = 3'd3,
        ST_UP          = 3'd4,
        ST_PRBS        = 3'd5
    } link_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/taxi_eth_phy_10g_link_ctrl.sv
// 10G BASE-R link controller: SERDES RX reset sequencing, lock qualification,
// link supervision, PRBS31 test mode and saturating link statistics.
module taxi_eth_phy_10g_link_ctrl
    import taxi_eth_phy_10g_link_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = 64,
    parameter int unsigned LOCK_TIMEOUT  = 100000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned ERR_CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_link_enable,
    input  logic                 cfg_prbs31_enable,
    input  logic                 stat_clear,
    input  logic                 serdes_rx_reset_req,
    input  logic                 rx_block_lock,
    input  logic                 rx_high_ber,
    input  logic                 rx_status,
    input  logic [6:0]           rx_error_count,
    output logic                 serdes_rx_reset,
    output logic                 cfg_tx_prbs31_enable,
    output logic                 cfg_rx_prbs31_enable,
    output logic                 link_up,
    output logic [2:0]           link_state,
    output logic [15:0]          stat_link_down_count,
    output logic [ERR_CNT_W-1:0] stat_prbs_err_count
);

    localparam int unsigned TMAX = max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] T_RESET  = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] T_STABLE = TW'(STABLE_CYCLES - 1);

    link_state_e          state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [15:0]          down_cnt_q, down_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_CNT_W:0]   err_sum;
    logic                 timer_zero;
    logic                 reset_req_ok;

    assign timer_zero   = (timer_q == '0);
    assign reset_req_ok = serdes_rx_reset_req &&
                          (state_q inside {ST_WAIT_LOCK, ST_WAIT_STABLE, ST_UP, ST_PRBS});

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!cfg_link_enable) begin
            state_d = ST_DISABLED;
            timer_d = '0;
        end else if (reset_req_ok) begin
            state_d = ST_RESET;
            timer_d = T_RESET;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d = ST_RESET;
                    timer_d = T_RESET;
                end
                ST_RESET: begin
                    if (timer_zero) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = T_LOCK;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (rx_block_lock && !rx_high_ber) begin
                        state_d = ST_WAIT_STABLE;
                        timer_d = T_STABLE;
                    end else if (timer_zero) begin
                        state_d = ST_RESET;
                        timer_d = T_RESET;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                ST_WAIT_STABLE: begin
                    if (!rx_block_lock || rx_high_ber) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = T_LOCK;
                    end else if (timer_zero) begin
                        // Lock qualified; without rx_status and PRBS we park at timer 0.
                        if (cfg_prbs31_enable) begin
                            state_d = ST_PRBS;
                        end else if (rx_status) begin
                            state_d = ST_UP;
                        end
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                ST_UP: begin
                    if (!rx_block_lock || !rx_status) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = T_LOCK;
                    end else if (cfg_prbs31_enable) begin
                        state_d = ST_RESET;
                        timer_d = T_RESET;
                    end
                end
                ST_PRBS: begin
                    if (!cfg_prbs31_enable) begin
                        state_d = ST_RESET;
                        timer_d = T_RESET;
                    end
                end
                default: begin
                    state_d = ST_DISABLED;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Saturating statistics; a clear in the same cycle discards any increment.
    assign err_sum = {1'b0, err_cnt_q} + (ERR_CNT_W + 1)'(rx_error_count);

    always_comb begin
        down_cnt_d = down_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (stat_clear) begin
            down_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            if (state_q == ST_UP && state_d != ST_UP && state_d != ST_DISABLED &&
                down_cnt_q != '1) begin
                down_cnt_d = down_cnt_q + 16'd1;
            end
            if (state_q == ST_PRBS) begin
                err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_DISABLED;
            timer_q    <= '0;
            down_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            down_cnt_q <= down_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign serdes_rx_reset      = (state_q == ST_RESET);
    assign link_up              = (state_q == ST_UP);
    assign cfg_rx_prbs31_enable = (state_q == ST_PRBS);
    assign cfg_tx_prbs31_enable = (state_q == ST_PRBS) ||
                                  (state_q == ST_WAIT_STABLE && cfg_prbs31_enable);
    assign link_state           = state_q;
    assign stat_link_down_count = down_cnt_q;
    assign stat_prbs_err_count  = err_cnt_q;

endmodule

// File: tb/tb_taxi_eth_phy_10g_link_ctrl.sv
// Directed bench for the 10G link controller with short timing parameters.
module tb_taxi_eth_phy_10g_link_ctrl;

    localparam logic [2:0] S_DIS = 3'd0, S_RST = 3'd1, S_WL = 3'd2,
                           S_WS = 3'd3, S_UP = 3'd4, S_PRBS = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_link_enable, cfg_prbs31_enable, stat_clear;
    logic        serdes_rx_reset_req, rx_block_lock, rx_high_ber, rx_status;
    logic [6:0]  rx_error_count;

    logic        serdes_rx_reset, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable, link_up;
    logic [2:0]  link_state;
    logic [15:0] stat_link_down_count;
    logic [31:0] stat_prbs_err_count;

    logic        n_serdes_rx_reset, n_tx_prbs, n_rx_prbs, n_link_up;
    logic [2:0]  n_link_state;
    logic [15:0] n_link_down_count;
    logic [7:0]  n_prbs_err_count;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    taxi_eth_phy_10g_link_ctrl #(
        .RESET_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .ERR_CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_link_enable(cfg_link_enable), .cfg_prbs31_enable(cfg_prbs31_enable),
        .stat_clear(stat_clear), .serdes_rx_reset_req(serdes_rx_reset_req),
        .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
        .rx_status(rx_status), .rx_error_count(rx_error_count),
        .serdes_rx_reset(serdes_rx_reset), .cfg_tx_prbs31_enable(cfg_tx_prbs31_enable),
        .cfg_rx_prbs31_enable(cfg_rx_prbs31_enable), .link_up(link_up),
        .link_state(link_state), .stat_link_down_count(stat_link_down_count),
        .stat_prbs_err_count(stat_prbs_err_count)
    );

    taxi_eth_phy_10g_link_ctrl #(
        .RESET_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .ERR_CNT_W(8)
    ) dut8 (
        .clk(clk), .rst(rst),
        .cfg_link_enable(cfg_link_enable), .cfg_prbs31_enable(cfg_prbs31_enable),
        .stat_clear(stat_clear), .serdes_rx_reset_req(serdes_rx_reset_req),
        .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
        .rx_status(rx_status), .rx_error_count(rx_error_count),
        .serdes_rx_reset(n_serdes_rx_reset), .cfg_tx_prbs31_enable(n_tx_prbs),
        .cfg_rx_prbs31_enable(n_rx_prbs), .link_up(n_link_up),
        .link_state(n_link_state), .stat_link_down_count(n_link_down_count),
        .stat_prbs_err_count(n_prbs_err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts consecutive samples spent in state s (bounded).
    task automatic count_state(input logic [2:0] s, output int cnt);
        cnt = 0;
        while (link_state === s && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int k;
        k = 0;
        while (link_state !== s && k < budget) begin
            k++;
            tick();
        end
        chk(tag, {29'd0, link_state}, {29'd0, s});
    endtask

    initial begin
        rst = 1'b1;
        cfg_link_enable = 1'b0; cfg_prbs31_enable = 1'b0; stat_clear = 1'b0;
        serdes_rx_reset_req = 1'b0; rx_block_lock = 1'b1; rx_high_ber = 1'b0;
        rx_status = 1'b1; rx_error_count = 7'd0;
        repeat (3) tick();
        chk("rst_state", {29'd0, link_state}, {29'd0, S_DIS});
        chk("rst_outs", {28'd0, serdes_rx_reset, cfg_tx_prbs31_enable,
                         cfg_rx_prbs31_enable, link_up}, 32'd0);
        chk("rst_down", {16'd0, stat_link_down_count}, 32'd0);
        chk("rst_err", stat_prbs_err_count, 32'd0);

        // Bring-up with lock held: RESET 4, WAIT_LOCK 1, WAIT_STABLE 8, then UP.
        rst = 1'b0;
        tick();
        chk("dis_hold", {29'd0, link_state}, {29'd0, S_DIS});
        cfg_link_enable = 1'b1;
        tick();
        count_state(S_RST, n);
        chk("reset_len", n, 32'd4);
        count_state(S_WL, n);
        chk("wl_len_lock", n, 32'd1);
        count_state(S_WS, n);
        chk("ws_len", n, 32'd8);
        chk("up_state", {29'd0, link_state}, {29'd0, S_UP});
        chk("up_link", {31'd0, link_up}, 32'd1);
        chk("up_down0", {16'd0, stat_link_down_count}, 32'd0);

        // One-cycle lock drop in UP.
        rx_block_lock = 1'b0;
        tick();
        rx_block_lock = 1'b1;
        chk("drop_state", {29'd0, link_state}, {29'd0, S_WL});
        chk("drop_link", {31'd0, link_up}, 32'd0);
        chk("drop_down", {16'd0, stat_link_down_count}, 32'd1);
        tick();
        count_state(S_WS, n);
        chk("relock_ws", n, 32'd8);
        chk("relock_up", {31'd0, link_up}, 32'd1);

        // reset_req from UP counts as link-down; then high_ber glitch at stable cycle 5.
        serdes_rx_reset_req = 1'b1;
        tick();
        serdes_rx_reset_req = 1'b0;
        chk("req_state", {29'd0, link_state}, {29'd0, S_RST});
        chk("req_down", {16'd0, stat_link_down_count}, 32'd2);
        count_state(S_RST, n);
        chk("req_reset_len", n, 32'd4);
        tick();
        chk("ws_enter", {29'd0, link_state}, {29'd0, S_WS});
        repeat (4) tick();
        rx_high_ber = 1'b1;
        tick();
        rx_high_ber = 1'b0;
        chk("ber_state", {29'd0, link_state}, {29'd0, S_WL});
        tick();
        count_state(S_WS, n);
        chk("ber_restart", n, 32'd8);
        chk("ber_up", {31'd0, link_up}, 32'd1);

        // No lock: RESET/WAIT_LOCK loop with a 24-cycle period.
        rx_block_lock = 1'b0;
        tick();
        chk("nolock_down", {16'd0, stat_link_down_count}, 32'd3);
        count_state(S_WL, n);
        chk("nolock_wl1", n, 32'd20);
        count_state(S_RST, n);
        chk("nolock_rst1", n, 32'd4);
        count_state(S_WL, n);
        chk("nolock_wl2", n, 32'd20);
        count_state(S_RST, n);
        chk("nolock_rst2", n, 32'd4);

        // PRBS entry, error accumulation and saturation (8-bit instance).
        rx_block_lock = 1'b1;
        cfg_prbs31_enable = 1'b1;
        wait_state("prbs_ws", S_WS, 40);
        chk("ws_tx_prbs", {30'd0, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable}, 32'd2);
        wait_state("prbs_enter", S_PRBS, 20);
        chk("prbs_outs", {29'd0, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable, link_up}, 32'd6);
        rx_error_count = 7'd3;
        repeat (10) tick();
        rx_error_count = 7'd0;
        chk("prbs_err30", stat_prbs_err_count, 32'd30);
        chk("prbs_err30_n", {24'd0, n_prbs_err_count}, 32'd30);
        rx_block_lock = 1'b0;
        rx_error_count = 7'd127;
        repeat (3) tick();
        chk("prbs_nolock", {29'd0, link_state}, {29'd0, S_PRBS});
        chk("prbs_err_wide", stat_prbs_err_count, 32'd411);
        chk("prbs_err_sat", {24'd0, n_prbs_err_count}, 32'd255);
        rx_error_count = 7'd5;
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        rx_error_count = 7'd0;
        chk("clr_err", stat_prbs_err_count, 32'd0);
        chk("clr_err_n", {24'd0, n_prbs_err_count}, 32'd0);
        chk("clr_down", {16'd0, stat_link_down_count}, 32'd0);

        // Leave PRBS, rebuild link, then disable + reset_req together.
        rx_block_lock = 1'b1;
        cfg_prbs31_enable = 1'b0;
        tick();
        chk("prbs_exit", {29'd0, link_state}, {29'd0, S_RST});
        wait_state("up_again", S_UP, 40);
        cfg_link_enable = 1'b0;
        serdes_rx_reset_req = 1'b1;
        tick();
        serdes_rx_reset_req = 1'b0;
        chk("dis_state", {29'd0, link_state}, {29'd0, S_DIS});
        chk("dis_down", {16'd0, stat_link_down_count}, 32'd0);
        chk("dis_state_n", {29'd0, n_link_state}, {29'd0, S_DIS});

        // Synchronous reset in the middle of RESET.
        cfg_link_enable = 1'b1;
        repeat (2) tick();
        chk("mid_reset", {31'd0, serdes_rx_reset}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rst2_state", {29'd0, link_state}, {29'd0, S_DIS});
        chk("rst2_outs", {28'd0, serdes_rx_reset, cfg_tx_prbs31_enable,
                          cfg_rx_prbs31_enable, link_up}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
